// File: rtl/fpregfile_commit_arb_pkg.sv
// fpregfile_commit_arb_pkg: shared commit-bus types, arbiter states and regfile geometry.
package fpregfile_commit_arb_pkg;

   localparam int NFPREGADDRMSB = 9;
   localparam int FPRF_ADDRW    = NFPREGADDRMSB + 1;
   localparam int NFPRFROWS     = 2 ** (FPRF_ADDRW - 1);

   typedef enum logic {FPRF_INIT, FPRF_RUN} fprf_arb_state_type;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   // ph_addr[0] picks the 32-bit half, ph_addr[FPRF_ADDRW-1:1] is the row
   typedef struct packed {
      logic [FPRF_ADDRW-1:0] ph_addr;
      logic [31:0]           ph1_data;
      logic [31:0]           ph2_data;
      logic                  ph1_parity;
      logic                  ph2_parity;
      logic                  ph1_we;
      logic                  ph2_we;
   } fpregfile_commit_type;

endpackage

// File: rtl/fpregfile_commit_arb_if.sv
// fpregfile_commit_arb_if: commit sources, scoreboard query and regfile write bus of the arbiter.
interface fpregfile_commit_arb_if
   import fpregfile_commit_arb_pkg::*;
#(
   parameter int ADDRW = FPRF_ADDRW
) ();

   logic                 fpu_valid;
   fpregfile_commit_type fpu_cmt;
   logic                 ld_valid;
   logic                 ld_ready;
   fpregfile_commit_type ld_cmt;
   logic [ADDRW-1:0]     chk_addr;
   logic                 chk_hit;
   fpregfile_commit_type rfc;
   logic                 busy;
   logic                 init_done;
   logic                 seq_err;

   modport master (
      output fpu_valid, fpu_cmt, ld_valid, ld_cmt, chk_addr,
      input  ld_ready, chk_hit, rfc, busy, init_done, seq_err
   );

   modport slave (
      input  fpu_valid, fpu_cmt, ld_valid, ld_cmt, chk_addr,
      output ld_ready, chk_hit, rfc, busy, init_done, seq_err
   );

endinterface

// File: rtl/fpregfile_commit_arb_cmt_fifo.sv
// fprf_cmt_fifo: register FIFO of load commits exposing per-entry valid and address for the hazard compare.
module fprf_cmt_fifo
   import fpregfile_commit_arb_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic                                 pop,
   input  fpregfile_commit_type                 din,
   output fpregfile_commit_type                 head,
   output logic [$clog2(QDEPTH):0]              count,
   output logic [QDEPTH-1:0]                    ent_vld,
   output logic [QDEPTH-1:0][FPRF_ADDRW-1:0]    ent_addr
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   fpregfile_commit_type mem [QDEPTH];
   logic [PW-1:0] wp, rp;

   always_ff @(posedge clk)
      if (push) mem[wp] <= din;

   // push never targets the slot being popped: ld_ready blocks pushes at full
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (push) begin
            wp          <= wp + 1'b1;
            ent_vld[wp] <= 1'b1;
         end
         if (pop) begin
            rp          <= rp + 1'b1;
            ent_vld[rp] <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end

   assign head = mem[rp];

   always_comb
      for (int i = 0; i < QDEPTH; i++) ent_addr[i] = mem[i].ph_addr;

endmodule

// File: rtl/fpregfile_commit_arb.sv
// fpregfile_commit_arb: merges FPU and FP-load commits onto the registered regfile write bus.
// Define FPREGFILE_INIT_EN to add a post-reset sweep that zeroes every row before RUN.
module fpregfile_commit_arb
   import fpregfile_commit_arb_pkg::*;
#(
   parameter int ADDRW  = FPRF_ADDRW,
   parameter int QDEPTH = 4
) (
   input iu_clk_type             gclk,
   input logic                   rst,
   fpregfile_commit_arb_if.slave bus
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int RW = ADDRW - 1;
`ifdef FPREGFILE_INIT_EN
   localparam fprf_arb_state_type RST_STATE = FPRF_INIT;
`else
   localparam fprf_arb_state_type RST_STATE = FPRF_RUN;
`endif

   logic                             clk;
   fprf_arb_state_type               state;
   logic [RW-1:0]                    row;
   logic [CW-1:0]                    count;
   logic [QDEPTH-1:0]                ent_vld;
   logic [QDEPTH-1:0][FPRF_ADDRW-1:0] ent_addr;
   fpregfile_commit_type             head, idle, sweep, rfc_d, rfc_q;
   logic                             init_done_q, seq_err_q, fpu_go, ld_acc, pop, byp, push, hit;

   assign clk          = gclk.clk;
   assign bus.ld_ready = !rst && state == FPRF_RUN && count < CW'(QDEPTH);
   assign ld_acc       = bus.ld_valid && bus.ld_ready;
   assign fpu_go       = bus.fpu_valid && init_done_q;
   assign pop          = state == FPRF_RUN && !fpu_go && count != '0;
   assign byp          = !fpu_go && count == '0 && ld_acc;
   assign push         = ld_acc && !byp;

   fprf_cmt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .din      (bus.ld_cmt),
      .head     (head),
      .count    (count),
      .ent_vld  (ent_vld),
      .ent_addr (ent_addr)
   );

   // an idle slot keeps address/data so the write port only sees the enables drop
   always_comb begin
      idle        = rfc_q;
      idle.ph1_we = 1'b0;
      idle.ph2_we = 1'b0;
      sweep         = '0;
      sweep.ph_addr = {row, 1'b0};
      sweep.ph1_we  = 1'b1;
      sweep.ph2_we  = 1'b1;
      rfc_d = state == FPRF_INIT ? sweep :
              fpu_go             ? bus.fpu_cmt :
              pop                ? head :
              byp                ? bus.ld_cmt : idle;
      hit = 1'b0;
      for (int i = 0; i < QDEPTH; i++)
         hit = hit | (ent_vld[i] && ((ent_addr[i] ^ bus.chk_addr) >> 1) == '0);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= RST_STATE;
         row         <= '0;
         rfc_q       <= '0;
         init_done_q <= 1'b0;
         seq_err_q   <= 1'b0;
      end else begin
         rfc_q       <= rfc_d;
         init_done_q <= state == FPRF_RUN;
         if (bus.fpu_valid && !init_done_q) seq_err_q <= 1'b1;
         if (state == FPRF_INIT) begin
            row <= row + 1'b1;
            if (row == RW'(NFPRFROWS - 1)) state <= FPRF_RUN;
         end
      end

   assign bus.rfc       = rfc_q;
   assign bus.busy      = count != '0;
   assign bus.chk_hit   = hit;
   assign bus.init_done = init_done_q;
   assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_fpregfile_commit_arb.sv
// tb_fpregfile_commit_arb: queue-based reference model and scoreboard for the commit arbiter.
module tb_fpregfile_commit_arb;
   import fpregfile_commit_arb_pkg::*;

   localparam int QDEPTH = 4;

   typedef struct {
      fpregfile_commit_type c;
      int                   cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   iu_clk_type gclk;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;
   bit         seq_exp = 1'b0;

   fpregfile_commit_type q[$];
   exp_t                 exp_q[$];
   fpregfile_commit_type last_wr = '0;

   fpregfile_commit_arb_if bus ();

   fpregfile_commit_arb #(.ADDRW(FPRF_ADDRW), .QDEPTH(QDEPTH)) dut (
      .gclk (gclk),
      .rst  (rst),
      .bus  (bus)
   );

   assign gclk.clk = clk;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string nm, input logic a, input logic e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b want %b (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic chkv(input string nm, input logic [127:0] a, input logic [127:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   function automatic fpregfile_commit_type rnd_cmt(input int amax);
      fpregfile_commit_type c;
      c.ph_addr    = FPRF_ADDRW'($urandom_range(0, amax));
      c.ph1_data   = $urandom;
      c.ph2_data   = $urandom;
      c.ph1_parity = 1'($urandom);
      c.ph2_parity = 1'($urandom);
      {c.ph1_we, c.ph2_we} = 2'($urandom_range(1, 3));
      return c;
   endfunction

   function automatic fpregfile_commit_type strip(input fpregfile_commit_type c);
      fpregfile_commit_type r = c;
      r.ph1_we = 1'b0;
      r.ph2_we = 1'b0;
      return r;
   endfunction

   function automatic bit model_hit(input logic [FPRF_ADDRW-1:0] a);
      foreach (q[i]) if (q[i].ph_addr / 2 == a / 2) return 1'b1;
      return 1'b0;
   endfunction

   // monitor: every write must be the oldest outstanding expectation, on its cycle
   always @(negedge clk)
      if (mon_en) begin
         if (bus.rfc.ph1_we || bus.rfc.ph2_we) begin
            if (exp_q.size() == 0) chkv("rfc_unexpected", 128'(bus.rfc), 128'(0));
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chkv("rfc_commit", 128'({bus.rfc, 32'(cyc)}), 128'({e.c, 32'(e.cyc)}));
            end
            last_wr = bus.rfc;
         end else chkv("rfc_idle_hold", 128'(strip(bus.rfc)), 128'(strip(last_wr)));
      end

   task automatic step(input bit fv, input fpregfile_commit_type fc, input bit lv,
                       input fpregfile_commit_type lc, input logic [FPRF_ADDRW-1:0] ca,
                       output bit acc);
      bit   mr, empty;
      exp_t e;
      @(negedge clk);
      bus.fpu_valid = fv;
      bus.fpu_cmt   = fc;
      bus.ld_valid  = lv;
      bus.ld_cmt    = lc;
      bus.chk_addr  = ca;
      #1;
      mr = q.size() < QDEPTH;
      chk1("ld_ready", bus.ld_ready, mr);
      chk1("busy", bus.busy, q.size() != 0);
      chk1("chk_hit", bus.chk_hit, model_hit(ca));
      chk1("seq_err", bus.seq_err, seq_exp);
      acc   = lv && mr;
      empty = q.size() == 0;
      e.cyc = cyc + 1;
      if (fv) begin
         e.c = fc;
         exp_q.push_back(e);
      end else if (!empty) begin
         e.c = q.pop_front();
         exp_q.push_back(e);
      end else if (acc) begin
         e.c = lc;
         exp_q.push_back(e);
      end
      if (acc && (fv || !empty)) q.push_back(lc);
   endtask

   task automatic idle_step();
      bit a;
      step(1'b0, rnd_cmt(1023), 1'b0, rnd_cmt(1023), FPRF_ADDRW'($urandom_range(0, 1023)), a);
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && q.size() > 0; i++) idle_step();
      idle_step();
   endtask

   // releases reset and walks through INIT (when built in) up to normal traffic
   task automatic release_rst(input bit poke);
      fpregfile_commit_type z = '0;
      @(negedge clk);
      rst           = 1'b0;
      bus.fpu_valid = poke;
      bus.fpu_cmt   = rnd_cmt(1023);
      bus.ld_valid  = 1'b0;
      #1;
      chk1("init_done_cycle0", bus.init_done, 1'b0);
`ifdef FPREGFILE_INIT_EN
      chk1("ld_ready_cycle0", bus.ld_ready, 1'b0);
      for (int k = 1; k <= NFPRFROWS; k++) begin
         @(negedge clk);
         bus.fpu_valid = 1'b0;
         z         = '0;
         z.ph_addr = FPRF_ADDRW'(2 * (k - 1));
         z.ph1_we  = 1'b1;
         z.ph2_we  = 1'b1;
         chkv("sweep_row", 128'(bus.rfc), 128'(z));
         if (k < NFPRFROWS) chk1("ld_ready_sweep", bus.ld_ready, 1'b0);
         chk1("init_done_sweep", bus.init_done, 1'b0);
      end
      @(negedge clk);
      chk1("init_done_rise", bus.init_done, 1'b1);
`else
      @(negedge clk);
      bus.fpu_valid = 1'b0;
      chk1("init_done_rise", bus.init_done, 1'b1);
      chkv("dropped_fpu_we", 128'({bus.rfc.ph1_we, bus.rfc.ph2_we}), 128'(0));
`endif
      chk1("seq_err_after_release", bus.seq_err, poke);
      seq_exp = poke;
      last_wr = z;
      mon_en  = 1'b1;
   endtask

   initial begin
      fpregfile_commit_type lc, fc;
      bit acc;
      int nacc;
      rst           = 1'b1;
      bus.fpu_valid = 1'b0;
      bus.fpu_cmt   = '0;
      bus.ld_valid  = 1'b0;
      bus.ld_cmt    = '0;
      bus.chk_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      chkv("reset_rfc", 128'(bus.rfc), 128'(0));
      chk1("reset_busy", bus.busy, 1'b0);
      chk1("reset_chk_hit", bus.chk_hit, 1'b0);
      chk1("reset_ld_ready", bus.ld_ready, 1'b0);
      chk1("reset_seq_err", bus.seq_err, 1'b0);
      chk1("reset_init_done", bus.init_done, 1'b0);
      release_rst(1'b1);

      lc          = '0;
      lc.ph_addr  = 10'h044;
      lc.ph1_data = 32'h3F800000;
      lc.ph1_we   = 1'b1;
      step(1'b0, rnd_cmt(1023), 1'b1, lc, 10'h044, acc);
      @(posedge clk);
      #1;
      chkv("bypass_rfc", 128'(bus.rfc), 128'(lc));
      chk1("bypass_busy", bus.busy, 1'b0);

      drain();
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, rnd_cmt(1023), i < 5, rnd_cmt(1023), 10'h3FF, acc);
         if (i == 4) chk1("ld_ready_full", bus.ld_ready, 1'b0);
         nacc += int'(acc);
      end
      chkv("ld_accepted", 128'(nacc), 128'(4));
      drain();

      lc         = rnd_cmt(1023);
      lc.ph_addr = 10'h101;
      step(1'b1, rnd_cmt(1023), 1'b1, lc, 10'h100, acc);
      step(1'b1, rnd_cmt(1023), 1'b0, lc, 10'h100, acc);
      chk1("chk_hit_row", bus.chk_hit, 1'b1);
      step(1'b1, rnd_cmt(1023), 1'b0, lc, 10'h102, acc);
      chk1("chk_hit_other_row", bus.chk_hit, 1'b0);
      step(1'b0, rnd_cmt(1023), 1'b0, lc, 10'h100, acc);
      chk1("chk_hit_popping", bus.chk_hit, 1'b1);
      step(1'b0, rnd_cmt(1023), 1'b0, lc, 10'h100, acc);
      chk1("chk_hit_after_pop", bus.chk_hit, 1'b0);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 3, rnd_cmt(15), $urandom_range(0, 9) < 6, rnd_cmt(15),
              FPRF_ADDRW'($urandom_range(0, 15)), acc);
      drain();
      chk1("seq_err_sticky", bus.seq_err, 1'b1);

      for (int i = 0; i < 3; i++) begin
         lc         = rnd_cmt(1023);
         lc.ph_addr = FPRF_ADDRW'(10'h0A0 + 2 * i);
         step(1'b1, rnd_cmt(1023), 1'b1, lc, 10'h0A0, acc);
      end
      #1;
      rst    = 1'b1;
      mon_en = 1'b0;
      q.delete();
      exp_q.delete();
      #1;
      chkv("rst_rfc", 128'(bus.rfc), 128'(0));
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_chk_hit", bus.chk_hit, 1'b0);
      chk1("rst_ld_ready", bus.ld_ready, 1'b0);
      chk1("rst_seq_err", bus.seq_err, 1'b0);
      bus.fpu_valid = 1'b0;
      bus.ld_valid  = 1'b0;
      @(posedge clk);
      release_rst(1'b0);

`ifdef FPREGFILE_INIT_EN
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chkv("sweep_rst_we", 128'({bus.rfc.ph1_we, bus.rfc.ph2_we}), 128'(0));
      @(posedge clk);
      release_rst(1'b0);
`endif

      for (int i = 0; i < 150; i++) begin
         fc = rnd_cmt(31);
         step($urandom_range(0, 9) < 4, fc, $urandom_range(0, 9) < 7, rnd_cmt(31),
              FPRF_ADDRW'($urandom_range(0, 31)), acc);
      end
      drain();
      @(negedge clk);
      @(negedge clk);
      chkv("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      chk1("seq_err_stays_clear", bus.seq_err, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fpregfile_commit_arb.md
Name: fpregfile_commit_arb

Overview:
- Write-port arbiter and sequencer for the double-pumped FP register file.
- Merges two commit sources into the single registered commit bus that feeds the regfile write port:
  - FPU result commits: fixed latency, cannot stall.
  - FP load commits (LDF/LDDF): valid/ready handshake.
- Load commits wait in a small FIFO and drain into idle write slots.
- Provides a pending-load address check for the FP scoreboard.

Parameters:
- ADDRW, 10: commit address width; equals NFPREGADDRMSB+1; bit 0 selects the 32-bit half, [ADDRW-1:1] is the row.
- QDEPTH, 4: load FIFO depth; power of two, at least 2.

Ports:
- gclk  in  iu_clk_type  pipeline clock bundle; only gclk.clk is used; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- fpu_valid  in  1  FPU commit present this cycle.
- fpu_cmt  in  fpregfile_commit_type  FPU commit: ph_addr, ph1/ph2 data, parity, we.
- ld_valid  in  1  load commit offered.
- ld_ready  out  1  load commit accepted when ld_valid&ld_ready.
- ld_cmt  in  fpregfile_commit_type  load commit payload.
- chk_addr  in  ADDRW  scoreboard query address.
- chk_hit  out  1  combinational; a queued load matches chk_addr[ADDRW-1:1].
- rfc  out  fpregfile_commit_type  registered commit to the regfile write port.
- busy  out  1  FIFO non-empty.
- init_done  out  1  regfile ready for normal traffic.
- seq_err  out  1  sticky; fpu_valid seen while init_done=0.

Behaviour:
- Reset (async, any time, including mid-sweep or with a non-empty FIFO):
  - rfc all zero, with ph1_we=ph2_we=0.
  - FIFO emptied; busy=0; chk_hit=0; seq_err=0.
  - ld_ready=0 during reset.
  - State returns to INIT (macro on) or RUN (macro off).
- States:
  - INIT: present only with the macro.
  - RUN: INIT->RUN when the sweep row counter reaches NROWS-1. RUN is terminal until reset.
- RUN, per cycle, priority order:
  1. fpu_valid=1: rfc <= fpu_cmt at the next edge (latency 1). Nothing dequeues.
  2. Else FIFO non-empty: rfc <= FIFO head at the next edge; head pops.
  3. Else ld_valid&ld_ready: bypass; rfc <= ld_cmt at the next edge; no enqueue (latency 1).
  4. Else rfc we bits <= 0; data/addr hold their previous values.
- Enqueue:
  - ld_valid&ld_ready enqueues unless the bypass in case 3 was taken.
  - Enqueue and pop in the same cycle leave the count unchanged.
- ld_ready = (state==RUN) && (count < QDEPTH). It is based on the registered count. At full it is 0 even if a pop occurs that cycle (no combinational ready path).
- Ordering:
  - Loads commit in acceptance order.
  - An FPU commit may overtake queued loads. The scoreboard must use chk_hit to hold FP issue to a row with a pending load.
- chk_hit: OR over valid FIFO entries of the row match. The bypassed load is not included, since it is already on rfc the next cycle.
- Pointers: log2(QDEPTH) bits, wrap naturally. count is log2(QDEPTH)+1 bits.
- rfc.ph1_we/ph2_we pass through unmodified, so a single-precision commit writes only one half. Parity fields pass through untouched.
- seq_err: set when fpu_valid=1 while init_done=0; cleared only by rst. The FPU commit is dropped in that case.
- NROWS = 2^(ADDRW-1).

Optional Feature:
- Macro: FPREGFILE_INIT_EN.
- Defined:
  - After reset the block sits in INIT for NROWS cycles.
  - Each INIT cycle drives rfc with ph_addr={row,1'b0}, all data 0, all parity 0, ph1_we=ph2_we=1; the row counter increments.
  - During INIT: init_done=0 and ld_ready=0.
  - RUN begins the cycle after the last row write; init_done=1 from then on.
- Undefined:
  - No INIT state; state is RUN directly.
  - init_done=1 one cycle after rst deasserts.
  - seq_err can then only fire in that one cycle.

Decomposition:
- libfp package:
  - fprf_arb_state_type enum {FPRF_INIT, FPRF_RUN}.
  - Constant NFPRFROWS.
  - Reuse fpregfile_commit_type.
- One sub-module: fprf_cmt_fifo. A QDEPTH-entry register FIFO of fpregfile_commit_type that exposes per-entry valid and address vectors for the chk_hit compare.

Test Plan:
- Macro on, reset release: 512 consecutive cycles of rfc.we=2'b11, addr 0,2,...,1022, data 0. init_done rises at cycle 513. ld_ready stays 0 throughout the sweep.
- Load bypass: RUN, FIFO empty, no FPU; ld_cmt addr 0x044, data 0x3F800000 -> rfc shows it the next cycle; busy stays 0.
- FPU contention: fpu_valid for 6 cycles while 5 loads are offered. Required response:
  - Exactly 4 loads accepted; ld_ready=0 on the 5th.
  - The 6 FPU commits appear back to back.
  - The 4 loads then drain in order on the following 4 cycles.
- Scoreboard check: one load to addr 0x101 queued behind an FPU burst. chk_addr=0x100 -> chk_hit=1. chk_addr=0x102 -> chk_hit=0. chk_hit drops the cycle after the load pops.
- Reset mid-operation: assert rst with 3 loads queued and mid-sweep -> rfc.we=0 immediately, busy=0, sweep restarts from row 0.
- Sequencing error: fpu_valid=1 during INIT -> seq_err=1 and stays 1; no FPU write on rfc.
